bin_to_gray_counter: RTL and testbench
======================================

Name: bin_to_gray_counter

Overview:
- Registered up/down binary counter whose state is also driven out as Gray code in the same cycle. It is the encode-side partner of the team's combinational Gray-to-binary decoder.
- Typical use: a Gray-coded pointer or position source whose output crosses into another domain, or feeds the decoder, so only one bit changes per step.
- Adds synchronous load, direction control, wrap or saturate at the ends, and wrap/step pulses.

Parameters:
- WIDTH, 4, counter and code width in bits (min 2).
- WRAP_EN, 1, 1 = modulo-2^WIDTH wrap at the ends; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance the counter one step this cycle.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_bin; takes priority over en.
- load_bin  input  WIDTH  binary value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- wrap  output  1  one-cycle pulse: the last step crossed the end of the range (wrap mode only).
- step  output  1  one-cycle pulse: the count changed by ±1 this cycle; 0 on load, hold or saturation.

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs.
- Reset: when rst=1 at an edge, bin_out=0, gray_out=0, wrap=0, step=0. rst overrides load and en, including in the middle of a count.
- Priority per edge: rst > load > en > hold.
- Next binary value nb:
  - load: nb = load_bin.
  - en&up: nb = bin_out+1.
  - en&!up: nb = bin_out-1.
  - otherwise: nb = bin_out.
- Arithmetic is unsigned, modulo 2^WIDTH.
- Gray encode: gray_out <= nb ^ (nb >> 1) (logical shift), registered on the same edge as bin_out. There is zero added latency between the two outputs.
- Invariant: after every edge, gray_out == bin_out ^ (bin_out >> 1).
- Boundaries with WRAP_EN=1:
  - up at all-ones goes to 0, with wrap=1 and step=1.
  - down at 0 goes to all-ones, with wrap=1 and step=1.
- Boundaries with WRAP_EN=0:
  - up at all-ones holds the value, with wrap=0 and step=0.
  - down at 0 holds the value, with wrap=0 and step=0.
- wrap and step are registered pulses aligned with the edge that updates bin_out. They deassert on the next edge unless re-triggered.
- Load:
  - Outputs reflect load_bin one edge later. wrap=0, step=0.
  - Loading the current value is legal and changes nothing except forcing both pulses to 0.
- load=1 and en=1 in the same cycle: load wins and en is ignored.
- en=0: hold all state, and wrap and step go to 0. up and load_bin are don't-care.
- Single-bit property: on any edge where step=1, gray_out differs from its previous value in exactly one bit. This includes wrap steps.

Test Plan:
- rst=1 for 2 cycles, then rst=0, en=1, up=1 for 17 cycles (WIDTH=4) -> gray_out steps through 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000. wrap=1 only on the 1000->0000 edge; step=1 on all 16 edges.
- Load 4'b1010 with en=0 -> next cycle bin_out=1010, gray_out=1111, step=0, wrap=0.
- From reset, en=1, up=0 for 1 cycle -> bin_out=1111, gray_out=1000, wrap=1. Continue 3 cycles -> bin 1100, gray 1010.
- load=1, load_bin=0101, en=1, up=1 in the same cycle -> bin_out=0101 (not 0110), gray_out=0111, step=0.
- Count up to bin 0110, then assert rst for 1 cycle with en=1 held -> bin_out=0, gray_out=0, no wrap. Counting resumes at 0001/0001 after rst drops.
- WRAP_EN=0: load 1111, en=1, up=1 for 3 cycles -> bin_out stays 1111, gray_out stays 1000, wrap=0, step=0.
- Then up=0 for 1 cycle -> 1110/1001, step=1.
- Continuous self-check on every run: gray_out == bin_out^(bin_out>>1), and the Hamming distance is 1 on every step=1 edge.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code copy of the same count.
// Supports synchronous load, wrap or saturate at the range ends, and wrap/step pulses.
module bin_to_gray_counter #(
    parameter int WIDTH   = 4,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             step
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;
    logic             next_step;
    logic             at_end;

    // Gray is encoded from the next value so both outputs update on the same edge.
    always_comb begin
        next_bin  = bin_out;
        next_wrap = 1'b0;
        next_step = 1'b0;
        at_end    = up ? (bin_out == MAX_VAL) : (bin_out == ZERO);

        if (load) begin
            next_bin = load_bin;
        end else if (en) begin
            if (!at_end) begin
                next_bin  = up ? (bin_out + ONE) : (bin_out - ONE);
                next_step = 1'b1;
            end else if (WRAP_EN) begin
                next_bin  = up ? ZERO : MAX_VAL;
                next_step = 1'b1;
                next_wrap = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= ZERO;
            gray_out <= ZERO;
            wrap     <= 1'b0;
            step     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= next_bin ^ (next_bin >> 1);
            wrap     <= next_wrap;
            step     <= next_step;
        end
    end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Bench for bin_to_gray_counter: a wrapping and a saturating instance share stimulus
// and are checked every cycle against an arithmetic model plus literal expectations.
module tb_bin_to_gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_bin = 4'd0;

    logic [3:0] bin_o  [2];
    logic [3:0] gray_o [2];
    logic       wrap_o [2];
    logic       step_o [2];

    int check_count = 0;
    int pass_count  = 0;
    bit check_en    = 1'b0;

    // Gray code of each binary value 0..15, written out by hand.
    logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int m_bin  [2] = '{0, 0};
    bit m_wrap [2] = '{1'b0, 1'b0};
    bit m_step [2] = '{1'b0, 1'b0};
    logic [3:0] prev_gray [2];
    bit prev_valid = 1'b0;

    always #5 clk = ~clk;

    bin_to_gray_counter #(.WIDTH(4), .WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .bin_out(bin_o[0]), .gray_out(gray_o[0]), .wrap(wrap_o[0]), .step(step_o[0])
    );

    bin_to_gray_counter #(.WIDTH(4), .WRAP_EN(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .bin_out(bin_o[1]), .gray_out(gray_o[1]), .wrap(wrap_o[1]), .step(step_o[1])
    );

    task automatic doCheck(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: plain integer counter in 0..15; instance 0 wraps, instance 1 saturates.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            m_step[k] = 1'b0;
            if (rst) begin
                m_bin[k] = 0;
            end else if (load) begin
                m_bin[k] = int'(load_bin);
            end else if (en) begin
                if (up) begin
                    if (m_bin[k] < 15) begin
                        m_bin[k] = m_bin[k] + 1;
                        m_step[k] = 1'b1;
                    end else if (k == 0) begin
                        m_bin[k] = 0;
                        m_step[k] = 1'b1;
                        m_wrap[k] = 1'b1;
                    end
                end else begin
                    if (m_bin[k] > 0) begin
                        m_bin[k] = m_bin[k] - 1;
                        m_step[k] = 1'b1;
                    end else if (k == 0) begin
                        m_bin[k] = 15;
                        m_step[k] = 1'b1;
                        m_wrap[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Continuous comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                doCheck($sformatf("model_bin[%0d]", k), 32'(bin_o[k]), 32'(m_bin[k]));
                doCheck($sformatf("model_gray[%0d]", k), 32'(gray_o[k]), 32'(gray_tbl[m_bin[k]]));
                doCheck($sformatf("model_wrap[%0d]", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
                doCheck($sformatf("model_step[%0d]", k), 32'(step_o[k]), 32'(m_step[k]));
                doCheck($sformatf("gray_invariant[%0d]", k), 32'(gray_o[k]),
                        32'(bin_o[k] ^ (bin_o[k] >> 1)));
                if (prev_valid && step_o[k] === 1'b1)
                    doCheck($sformatf("hamming_one[%0d]", k),
                            32'($countones(gray_o[k] ^ prev_gray[k])), 32'd1);
                prev_gray[k] = gray_o[k];
            end
            prev_valid = 1'b1;
        end
    end

    task automatic applyStimulus(input bit r, input bit ld, input logic [3:0] lb,
                                 input bit e, input bit u);
        @(negedge clk);
        rst = r; load = ld; load_bin = lb; en = e; up = u;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int k, input logic [3:0] eb,
                               input logic [3:0] eg, input bit ew, input bit es);
        doCheck({name, "_bin"},  32'(bin_o[k]),  32'(eb));
        doCheck({name, "_gray"}, 32'(gray_o[k]), 32'(eg));
        doCheck({name, "_wrap"}, 32'(wrap_o[k]), 32'(ew));
        doCheck({name, "_step"}, 32'(step_o[k]), 32'(es));
    endtask

    logic [3:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        applyStimulus(1, 0, 4'd0, 0, 1);
        check_en = 1'b1;
        applyStimulus(1, 0, 4'd0, 1, 1);
        checkOutput("reset_w", 0, 4'b0000, 4'b0000, 0, 0);
        checkOutput("reset_s", 1, 4'b0000, 4'b0000, 0, 0);

        // Full count-up lap: wrap only on the last edge.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 4'd0, 1, 1);
            doCheck($sformatf("lap_gray_%0d", i), 32'(gray_o[0]), 32'(up_seq[i]));
            doCheck($sformatf("lap_wrap_%0d", i), 32'(wrap_o[0]), 32'(i == 15));
            doCheck($sformatf("lap_step_%0d", i), 32'(step_o[0]), 32'd1);
        end
        checkOutput("sat_top", 1, 4'b1111, 4'b1000, 0, 0);

        applyStimulus(0, 1, 4'b1010, 0, 1);
        checkOutput("load_w", 0, 4'b1010, 4'b1111, 0, 0);
        checkOutput("load_s", 1, 4'b1010, 4'b1111, 0, 0);

        applyStimulus(0, 0, 4'd3, 0, 0);
        checkOutput("hold_w", 0, 4'b1010, 4'b1111, 0, 0);

        applyStimulus(1, 0, 4'd0, 0, 0);
        applyStimulus(0, 0, 4'd0, 1, 0);
        checkOutput("down_wrap_w", 0, 4'b1111, 4'b1000, 1, 1);
        checkOutput("down_sat_s", 1, 4'b0000, 4'b0000, 0, 0);
        repeat (3) applyStimulus(0, 0, 4'd0, 1, 0);
        checkOutput("down3_w", 0, 4'b1100, 4'b1010, 0, 1);

        applyStimulus(0, 1, 4'b0101, 1, 1);
        checkOutput("load_beats_en", 0, 4'b0101, 4'b0111, 0, 0);

        applyStimulus(0, 0, 4'd0, 1, 1);
        checkOutput("up_to_6", 0, 4'b0110, 4'b0101, 0, 1);
        applyStimulus(1, 0, 4'd0, 1, 1);
        checkOutput("mid_reset", 0, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 4'd0, 1, 1);
        checkOutput("resume", 0, 4'b0001, 4'b0001, 0, 1);

        applyStimulus(0, 1, 4'b1111, 0, 1);
        repeat (3) begin
            applyStimulus(0, 0, 4'd0, 1, 1);
            checkOutput("sat_hold", 1, 4'b1111, 4'b1000, 0, 0);
        end
        checkOutput("wrap_after3", 0, 4'b0010, 4'b0011, 0, 1);
        applyStimulus(0, 0, 4'd0, 1, 0);
        checkOutput("sat_down", 1, 4'b1110, 4'b1001, 0, 1);

        applyStimulus(0, 1, 4'b1110, 0, 0);
        checkOutput("reload_same", 1, 4'b1110, 4'b1001, 0, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
